// File: rtl/dec_enc_unit.sv
// One-hot decode plus bit-serial priority encode and population count,
// with valid/ready handshakes on both request and result sides.
module dec_enc_unit #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [OUT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_found
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [1:0] M_DEC  = 2'd0;
    localparam logic [1:0] M_LOW  = 2'd1;
    localparam logic [1:0] M_HIGH = 2'd2;

    localparam logic [IN_W-1:0]  IDX_MAX = IN_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [OUT_W-1:0] vec_q, vec_d;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic [OUT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             found_q, found_d;

    logic             hit;
    logic [OUT_W-1:0] idx_ext;

    assign hit     = vec_q[idx_q];
    assign idx_ext = OUT_W'(idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            vec_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            found_q <= found_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        found_d = found_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mode_d = mode;
                    vec_d  = in_data;
                    cnt_d  = '0;
                    unique case (mode)
                        M_DEC: begin
                            data_d  = ONE << in_data[IN_W-1:0];
                            found_d = 1'b1;
                            state_d = DONE;
                        end
                        M_HIGH: begin
                            idx_d   = IDX_MAX;
                            state_d = SCAN;
                        end
                        default: begin
                            idx_d   = '0;
                            state_d = SCAN;
                        end
                    endcase
                end
            end
            SCAN: begin
                unique case (mode_q)
                    M_LOW: begin
                        if (hit) begin
                            data_d  = idx_ext;
                            found_d = 1'b1;
                            state_d = DONE;
                        end else if (idx_q == IDX_MAX) begin
                            data_d  = '0;
                            found_d = 1'b0;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                    M_HIGH: begin
                        if (hit) begin
                            data_d  = idx_ext;
                            found_d = 1'b1;
                            state_d = DONE;
                        end else if (idx_q == '0) begin
                            data_d  = '0;
                            found_d = 1'b0;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end
                    default: begin
                        // popcount: the last bit is folded in on the final edge
                        cnt_d = cnt_q + OUT_W'(hit);
                        if (idx_q == IDX_MAX) begin
                            data_d  = cnt_d;
                            found_d = |cnt_d;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                endcase
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_found = found_q;

endmodule

// File: tb/tb_dec_enc_unit.sv
// Scoreboard bench for dec_enc_unit: directed requests push expectations,
// monitors pop and compare on each rising out_valid.
module tb_dec_enc_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_found;
    logic [1:0]  a_mode = '0;
    logic [3:0]  a_in_data = '0, a_out_data;
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_found;
    logic [1:0]  b_mode = '0;
    logic [15:0] b_in_data = '0, b_out_data;

    dec_enc_unit #(.IN_W(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mode(a_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_found(a_out_found)
    );

    dec_enc_unit #(.IN_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_found(b_out_found)
    );

    typedef struct {
        logic [15:0] d;
        logic        f;
        int          acc;
        int          lat;
        string       nm;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   errs = 0;
    int   checks = 0;
    int   edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        errs++;
        $display("FAIL %s", nm);
    endtask

    logic pv_a = 1'b0;
    always @(negedge clk) begin
        if (a_out_valid && !pv_a) begin
            if (q_a.size() == 0) begin
                bad($sformatf("a_unexpected_result data=%0h", a_out_data));
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk({e.nm, "_data"}, 32'(a_out_data), 32'(e.d));
                chk({e.nm, "_found"}, 32'(a_out_found), 32'(e.f));
                chk({e.nm, "_latency"}, 32'(edge_n - e.acc), 32'(e.lat));
            end
        end
        pv_a = a_out_valid;
    end

    logic pv_b = 1'b0;
    always @(negedge clk) begin
        if (b_out_valid && !pv_b) begin
            if (q_b.size() == 0) begin
                bad($sformatf("b_unexpected_result data=%0h", b_out_data));
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk({e.nm, "_data"}, 32'(b_out_data), 32'(e.d));
                chk({e.nm, "_found"}, 32'(b_out_found), 32'(e.f));
                chk({e.nm, "_latency"}, 32'(edge_n - e.acc), 32'(e.lat));
            end
        end
        pv_b = b_out_valid;
    end

    task automatic send_a(input string nm, input logic [1:0] m, input logic [3:0] d,
                          input logic [3:0] ed, input logic ef, input int lat,
                          input bit hold);
        int t = 0;
        @(negedge clk);
        while (!a_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!a_in_ready) begin
            bad({nm, "_in_ready_timeout"});
            return;
        end
        a_mode     = m;
        a_in_data  = d;
        a_in_valid = 1'b1;
        q_a.push_back('{d: 16'(ed), f: ef, acc: edge_n, lat: lat, nm: nm});
        @(posedge clk);
        #1;
        if (!hold) a_in_valid = 1'b0;
    endtask

    task automatic send_b(input string nm, input logic [1:0] m, input logic [15:0] d,
                          input logic [15:0] ed, input logic ef, input int lat);
        int t = 0;
        @(negedge clk);
        while (!b_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!b_in_ready) begin
            bad({nm, "_in_ready_timeout"});
            return;
        end
        b_mode     = m;
        b_in_data  = d;
        b_in_valid = 1'b1;
        q_b.push_back('{d: ed, f: ef, acc: edge_n, lat: lat, nm: nm});
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(a_in_ready && b_in_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!(a_in_ready && b_in_ready)) bad("wait_idle_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(a_in_ready), 0);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_data", 32'(a_out_data), 0);
        chk("rst_out_found", 32'(a_out_found), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(a_in_ready), 1);

        send_a("dec2", 2'b00, 4'b0010, 4'b0100, 1'b1, 1, 1'b0);
        send_a("low_1010", 2'b01, 4'b1010, 4'd1, 1'b1, 3, 1'b0);
        send_a("high_1010", 2'b10, 4'b1010, 4'd3, 1'b1, 2, 1'b0);

        // in_valid stays high and the operand changes during the scan
        send_a("low_0000", 2'b01, 4'b0000, 4'd0, 1'b0, 5, 1'b1);
        a_in_data = 4'b1111;
        a_mode    = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(a_in_ready), 0);
        end
        a_in_valid = 1'b0;

        send_a("high_0000", 2'b10, 4'b0000, 4'd0, 1'b0, 5, 1'b0);
        send_a("pop_1111", 2'b11, 4'b1111, 4'd4, 1'b1, 5, 1'b0);
        send_a("pop_0000", 2'b11, 4'b0000, 4'd0, 1'b0, 5, 1'b0);
        send_a("pop_1011", 2'b11, 4'b1011, 4'd3, 1'b1, 5, 1'b0);
        send_a("high_0001", 2'b10, 4'b0001, 4'd0, 1'b1, 5, 1'b0);
        send_a("low_1000", 2'b01, 4'b1000, 4'd3, 1'b1, 5, 1'b0);
        send_a("dec0", 2'b00, 4'b1100, 4'b0001, 1'b1, 1, 1'b0);

        // consumer stall
        wait_idle();
        a_out_ready = 1'b0;
        send_a("bp_low_0100", 2'b01, 4'b0100, 4'd2, 1'b1, 4, 1'b0);
        begin
            int t = 0;
            while (!a_out_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!a_out_valid) bad("bp_out_valid_timeout");
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(a_out_valid), 1);
            chk("bp_out_data", 32'(a_out_data), 2);
            chk("bp_in_ready", 32'(a_in_ready), 0);
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(a_out_valid), 0);
        chk("bp_release_data_kept", 32'(a_out_data), 2);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(a_in_ready), 1);

        // asynchronous reset in the middle of a popcount scan
        a_mode     = 2'b11;
        a_in_data  = 4'b1111;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(a_out_valid), 0);
        chk("arst_out_data", 32'(a_out_data), 0);
        chk("arst_out_found", 32'(a_out_found), 0);
        chk("arst_in_ready", 32'(a_in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        send_a("dec3_after_rst", 2'b00, 4'b0011, 4'b1000, 1'b1, 1, 1'b0);

        send_b("w4_high_0100", 2'b10, 16'h0100, 16'd8, 1'b1, 9);
        send_b("w4_pop_f0f1", 2'b11, 16'hF0F1, 16'd9, 1'b1, 17);
        send_b("w4_low_8000", 2'b01, 16'h8000, 16'd15, 1'b1, 17);
        send_b("w4_dec_9", 2'b00, 16'hFFF9, 16'h0200, 1'b1, 1);

        wait_idle();
        repeat (2) @(negedge clk);
        chk("a_queue_drained", 32'(q_a.size()), 0);
        chk("b_queue_drained", 32'(q_b.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
